druaga_rom_loader: RTL and testbench

DRUAGA_ROM_LOADER -- requirements
Module: druaga_rom_loader

---
 rtl/druaga_rom_loader.sv | 146 ++++++++++++++
 tb/tb_druaga_rom_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/druaga_rom_loader.sv
// ROM download loader: takes a header byte (game model) followed by the ROM image
// and writes the image bytes through a 4-entry FIFO, keeping a minimum spacing between writes.
module druaga_rom_loader #(
    parameter int unsigned ROM_BYTES = 17'h13600,
    parameter int unsigned GAP       = 2
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        DL_START,
    input  logic        DL_VALID,
    input  logic [7:0]  DL_DATA,
    output logic        DL_READY,
    output logic        ROMCL,
    output logic [16:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic [2:0]  MODEL,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVF,
    output logic [7:0]  CSUM
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    localparam logic [16:0] LAST_AD    = 17'(ROM_BYTES - 1);
    localparam logic [3:0]  GAP_RELOAD = 4'(GAP - 1);

    logic [1:0]  state;
    logic [7:0]  fifo [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [3:0]  gap_cnt;
    logic [16:0] addr;

    logic pop_rdy;
    logic pop;
    logic accept;
    logic push;
    logic last_pop;

    assign ROMCL = MCLK;
    assign BUSY  = (state == S_HEADER) || (state == S_LOAD);
    assign DONE  = (state == S_FIN);

    // pop_rdy ignores DL_START so the ready path does not depend on the restart pulse
    assign pop_rdy  = (state == S_LOAD) && (count != 3'd0) && (gap_cnt == 4'd0)
                      && (32'(addr) < ROM_BYTES);
    assign pop      = pop_rdy && !DL_START;
    assign accept   = DL_VALID && DL_READY && !DL_START;
    assign push     = accept && (state == S_LOAD);
    assign last_pop = pop && (addr == LAST_AD);

    always_comb begin
        DL_READY = 1'b0;
        case (state)
            S_HEADER: DL_READY = 1'b1;
            S_LOAD:   DL_READY = (count != 3'd4) || pop_rdy;
            S_FIN:    DL_READY = 1'b1;
            default:  DL_READY = 1'b0;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (push)
            fifo[wr_ptr] <= DL_DATA;
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            gap_cnt <= '0;
            addr    <= '0;
            CSUM    <= '0;
            ROMAD   <= '0;
            ROMDT   <= '0;
            ROMEN   <= 1'b0;
            MODEL   <= '0;
            OVF     <= 1'b0;
        end else begin
            ROMEN <= 1'b0;
            if (DL_START) begin
                state   <= S_HEADER;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                gap_cnt <= '0;
                addr    <= '0;
                CSUM    <= '0;
                OVF     <= 1'b0;
            end else begin
                if (gap_cnt != 4'd0)
                    gap_cnt <= gap_cnt - 4'd1;
                case (state)
                    S_HEADER: begin
                        if (accept) begin
                            MODEL <= DL_DATA[2:0];
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (pop) begin
                            ROMDT   <= fifo[rd_ptr];
                            ROMAD   <= addr;
                            ROMEN   <= 1'b1;
                            gap_cnt <= GAP_RELOAD;
                            addr    <= addr + 17'd1;
                            CSUM    <= CSUM + fifo[rd_ptr];
                            rd_ptr  <= rd_ptr + 2'd1;
                        end
                        // final write: leftover or same-cycle bytes are dropped and flagged
                        if (last_pop) begin
                            state  <= S_FIN;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            count  <= '0;
                            if ((count > 3'd1) || push)
                                OVF <= 1'b1;
                        end else begin
                            if (push)
                                wr_ptr <= wr_ptr + 2'd1;
                            case ({push, pop})
                                2'b10:   count <= count + 3'd1;
                                2'b01:   count <= count - 3'd1;
                                default: count <= count;
                            endcase
                        end
                    end
                    S_FIN: begin
                        if (accept)
                            OVF <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_druaga_rom_loader.sv
// Scoreboard bench for druaga_rom_loader: three parameterisations share one stimulus
// bus, selected by sel; expected ROM writes are queued at drive time and popped on ROMEN.
module tb_druaga_rom_loader;

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DL_START = 1'b0;
    logic       DL_VALID = 1'b0;
    logic [7:0] DL_DATA = 8'h00;
    logic [1:0] sel = 2'd0;

    always #5 MCLK = ~MCLK;

    logic        rdy [3];
    logic        cl  [3];
    logic        en  [3];
    logic        busy[3];
    logic        done[3];
    logic        ovf [3];
    logic [16:0] ad  [3];
    logic [7:0]  dt  [3];
    logic [7:0]  cs  [3];
    logic [2:0]  mdl [3];

    druaga_rom_loader #(.ROM_BYTES(4), .GAP(2)) u0 (
        .MCLK(MCLK), .RESET(RESET),
        .DL_START(DL_START && sel == 2'd0), .DL_VALID(DL_VALID && sel == 2'd0), .DL_DATA(DL_DATA),
        .DL_READY(rdy[0]), .ROMCL(cl[0]), .ROMAD(ad[0]), .ROMDT(dt[0]), .ROMEN(en[0]),
        .MODEL(mdl[0]), .BUSY(busy[0]), .DONE(done[0]), .OVF(ovf[0]), .CSUM(cs[0]));

    druaga_rom_loader #(.ROM_BYTES(8), .GAP(15)) u1 (
        .MCLK(MCLK), .RESET(RESET),
        .DL_START(DL_START && sel == 2'd1), .DL_VALID(DL_VALID && sel == 2'd1), .DL_DATA(DL_DATA),
        .DL_READY(rdy[1]), .ROMCL(cl[1]), .ROMAD(ad[1]), .ROMDT(dt[1]), .ROMEN(en[1]),
        .MODEL(mdl[1]), .BUSY(busy[1]), .DONE(done[1]), .OVF(ovf[1]), .CSUM(cs[1]));

    druaga_rom_loader #(.GAP(1)) u2 (
        .MCLK(MCLK), .RESET(RESET),
        .DL_START(DL_START && sel == 2'd2), .DL_VALID(DL_VALID && sel == 2'd2), .DL_DATA(DL_DATA),
        .DL_READY(rdy[2]), .ROMCL(cl[2]), .ROMAD(ad[2]), .ROMDT(dt[2]), .ROMEN(en[2]),
        .MODEL(mdl[2]), .BUSY(busy[2]), .DONE(done[2]), .OVF(ovf[2]), .CSUM(cs[2]));

    logic        o_rdy, o_cl, o_en, o_busy, o_done, o_ovf;
    logic [16:0] o_ad;
    logic [7:0]  o_dt, o_cs;
    logic [2:0]  o_mdl;
    assign o_rdy  = rdy[sel];
    assign o_cl   = cl[sel];
    assign o_en   = en[sel];
    assign o_busy = busy[sel];
    assign o_done = done[sel];
    assign o_ovf  = ovf[sel];
    assign o_ad   = ad[sel];
    assign o_dt   = dt[sel];
    assign o_cs   = cs[sel];
    assign o_mdl  = mdl[sel];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int min_gap = 1;
    int acc_cyc = 0;
    logic [16:0] last_ad = '0;
    logic [24:0] exp_q[$];

    always @(posedge MCLK) cyc <= cyc + 1;

    // Scoreboard monitor: every ROMEN must match the oldest expected write
    always @(negedge MCLK) begin
        logic [24:0] e;
        if (o_en === 1'b1) begin
            if (pulses == 0) first_cyc = cyc;
            else begin
                checks++;
                if (cyc - last_cyc < min_gap) begin
                    failures++;
                    $display("FAIL romen_spacing actual=%0d required>=%0d", cyc - last_cyc, min_gap);
                end
            end
            pulses++;
            last_cyc = cyc;
            last_ad  = o_ad;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_romen actual ad=%h dt=%h required=no pulse", o_ad, o_dt);
            end else begin
                e = exp_q.pop_front();
                if ({o_ad, o_dt} !== e) begin
                    failures++;
                    $display("FAIL rom_write actual ad=%h dt=%h required ad=%h dt=%h",
                             o_ad, o_dt, e[24:8], e[7:0]);
                end
            end
        end
    end

    task automatic begin_test(input logic [1:0] s, input int g);
        sel = s;
        min_gap = g;
        pulses = 0;
        exp_q.delete();
    endtask

    task automatic start();
        DL_START = 1'b1;
        @(posedge MCLK); #1;
        DL_START = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        DL_VALID = 1'b1;
        DL_DATA = b;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge MCLK);
            ok = (o_rdy === 1'b1);
            @(posedge MCLK); #1;
            if (!ok) stalls++;
        end
        acc_cyc = cyc;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not accepted required=accepted byte %h", b);
        end
    endtask

    task automatic wait_done(input int limit);
        for (int n = 0; n < limit && o_done !== 1'b1; n++) @(negedge MCLK);
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout actual=%b required=1", o_done);
        end
        @(posedge MCLK); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge MCLK);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rdy[k], en[k], ad[k], dt[k], mdl[k], busy[k], done[k], ovf[k], cs[k]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d actual=%h required=0", k,
                         {rdy[k], en[k], ad[k], dt[k], mdl[k], busy[k], done[k], ovf[k], cs[k]});
            end
        end
        checks++;
        if (o_cl !== 1'b0) begin
            failures++;
            $display("FAIL romcl_low actual=%b required=0", o_cl);
        end
        @(posedge MCLK); #1;
        checks++;
        if (o_cl !== 1'b1) begin
            failures++;
            $display("FAIL romcl_high actual=%b required=1", o_cl);
        end
        RESET = 1'b0;
        DL_VALID = 1'b1;
        DL_DATA = 8'h77;
        repeat (5) @(negedge MCLK);
        checks++;
        if (o_rdy !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready actual rdy=%b busy=%b required rdy=0 busy=0", o_rdy, o_busy);
        end
        @(posedge MCLK); #1;
        DL_VALID = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] s[5] = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
        int st, acc1;
        acc1 = 0;
        begin_test(2'd0, 2);
        start();
        @(negedge MCLK);
        chk("header_busy_ready", {30'd0, o_busy, o_rdy}, 32'd3);
        @(posedge MCLK); #1;
        for (int i = 0; i < 5; i++) begin
            if (i >= 1) exp_q.push_back({17'(i - 1), s[i]});
            send(s[i], st);
            if (i == 1) acc1 = acc_cyc;
        end
        DL_VALID = 1'b0;
        wait_done(100);
        chk("basic_model", 32'(o_mdl), 32'd5);
        chk("basic_csum", 32'(o_cs), 32'hAA);
        chk("basic_busy_ovf", {30'd0, o_busy, o_ovf}, 32'd0);
        chk("fin_ready", 32'(o_rdy), 32'd1);
        chk("basic_pulses", 32'(pulses), 32'd4);
        chk("basic_alternate", 32'(last_cyc - first_cyc), 32'd6);
        chk("basic_latency", 32'(first_cyc - acc1), 32'd1);
        chk("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_overflow();
        logic [7:0] s[6] = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int st;
        begin_test(2'd0, 2);
        start();
        for (int i = 0; i < 6; i++) begin
            if (i >= 1 && i <= 4) exp_q.push_back({17'(i - 1), s[i]});
            send(s[i], st);
        end
        DL_VALID = 1'b0;
        wait_done(100);
        repeat (10) @(posedge MCLK);
        #1;
        chk("ovf_flag", 32'(o_ovf), 32'd1);
        chk("ovf_done", 32'(o_done), 32'd1);
        chk("ovf_pulses", 32'(pulses), 32'd4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int st, first_stall, stall_total;
        first_stall = -1;
        stall_total = 0;
        begin_test(2'd1, 15);
        start();
        send(8'h09, st);
        for (int i = 0; i < 8; i++) begin
            b = 8'(8'hC0 + 8'(i * 7));
            exp_q.push_back({17'(i), b});
            send(b, st);
            if (st > 0 && first_stall < 0) first_stall = i;
            stall_total += st;
        end
        DL_VALID = 1'b0;
        wait_done(500);
        chk("bp_first_stall", 32'(first_stall), 32'd5);
        chk("bp_stalled", 32'(stall_total > 0), 32'd1);
        chk("bp_pulses", 32'(pulses), 32'd8);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("bp_model", 32'(o_mdl), 32'd1);
    endtask

    task automatic test_restart();
        logic [7:0] sum;
        int st;
        begin_test(2'd0, 2);
        // DL_START together with a valid byte: the byte must be dropped
        DL_VALID = 1'b1;
        DL_DATA = 8'h07;
        start();
        DL_VALID = 1'b0;
        @(negedge MCLK);
        chk("start_wins_model", 32'(o_mdl), 32'd5);
        chk("start_clears", {28'd0, o_busy, o_done, o_ovf, 1'b0}, 32'h8);
        chk("start_csum", 32'(o_cs), 32'd0);
        @(posedge MCLK); #1;
        send(8'h03, st);
        exp_q.push_back({17'd0, 8'hA1});
        send(8'hA1, st);
        exp_q.push_back({17'd1, 8'hA2});
        send(8'hA2, st);
        DL_VALID = 1'b0;
        for (int n = 0; n < 50 && pulses < 2; n++) @(negedge MCLK);
        chk("restart_two_writes", 32'(pulses), 32'd2);
        chk("restart_partial_csum", 32'(o_cs), 32'h43);
        @(posedge MCLK); #1;
        start();
        @(negedge MCLK);
        chk("restart_csum_clear", 32'(o_cs), 32'd0);
        chk("restart_model_kept", 32'(o_mdl), 32'd3);
        @(posedge MCLK); #1;
        send(8'h06, st);
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({17'(i), 8'(8'hB1 + 8'(i))});
            sum = sum + 8'(8'hB1 + 8'(i));
            send(8'(8'hB1 + 8'(i)), st);
        end
        DL_VALID = 1'b0;
        wait_done(100);
        chk("restart_model", 32'(o_mdl), 32'd6);
        chk("restart_csum", 32'(o_cs), 32'(sum));
        chk("restart_pulses", 32'(pulses), 32'd6);
    endtask

    task automatic test_reset_mid();
        int st, rdy_seen;
        rdy_seen = 0;
        begin_test(2'd0, 2);
        start();
        send(8'h01, st);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({17'(i), 8'(8'h10 * (i + 1))});
            send(8'(8'h10 * (i + 1)), st);
        end
        RESET = 1'b1;
        DL_VALID = 1'b0;
        exp_q.delete();
        @(negedge MCLK);
        checks++;
        if ({rdy[0], en[0], ad[0], dt[0], mdl[0], busy[0], done[0], ovf[0], cs[0]} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs actual=%h required=0",
                     {rdy[0], en[0], ad[0], dt[0], mdl[0], busy[0], done[0], ovf[0], cs[0]});
        end
        repeat (2) @(posedge MCLK);
        #1;
        RESET = 1'b0;
        DL_VALID = 1'b1;
        DL_DATA = 8'h5A;
        for (int n = 0; n < 20; n++) begin
            @(negedge MCLK);
            if (o_rdy !== 1'b0) rdy_seen++;
        end
        @(posedge MCLK); #1;
        DL_VALID = 1'b0;
        chk("midreset_idle_ready", 32'(rdy_seen), 32'd0);
        chk("midreset_pulses", 32'(pulses), 32'd1);
        start();
        send(8'h02, st);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({17'(i), 8'(8'h60 + 8'(i))});
            send(8'(8'h60 + 8'(i)), st);
        end
        DL_VALID = 1'b0;
        wait_done(100);
        chk("midreset_recover_model", 32'(o_mdl), 32'd2);
        chk("midreset_recover_pulses", 32'(pulses), 32'd5);
    endtask

    task automatic test_full_image();
        logic [7:0] sum, b;
        int st;
        sum = 8'h00;
        begin_test(2'd2, 1);
        start();
        send(8'h02, st);
        for (int i = 0; i < 32'h13600; i++) begin
            b = 8'($urandom);
            sum = sum + b;
            exp_q.push_back({17'(i), b});
            send(b, st);
        end
        DL_VALID = 1'b0;
        wait_done(50);
        chk("full_last_addr", 32'(last_ad), 32'h135FF);
        chk("full_csum", 32'(o_cs), 32'(sum));
        chk("full_pulses", 32'(pulses), 32'h13600);
        chk("full_ovf", 32'(o_ovf), 32'd0);
        chk("full_model", 32'(o_mdl), 32'd2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_full_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
